// File: rtl/pingpong_complex_buffer.sv
// Two-bank ping-pong buffer for complex samples: one bank fills lane-group by lane-group
// while the other drains full words. Banks swap on commit (writer) and release (reader).
module pingpong_complex_buffer #(
    parameter int LANES      = 16,
    parameter int DEPTH_BITS = 9,
    parameter int WR_GROUPS  = 2,
    parameter int CW         = 32,
    localparam int GB        = (WR_GROUPS > 1) ? $clog2(WR_GROUPS) : 1,
    localparam int CNTW      = DEPTH_BITS + $clog2(WR_GROUPS) + 1,
    localparam int LPG       = LANES / WR_GROUPS,
    localparam int GWD       = LPG * 2 * CW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DEPTH_BITS-1:0]   wr_addr,
    input  logic [GB-1:0]           wr_group,
    input  logic [GWD-1:0]          wr_data,
    input  logic                    wr_commit,
    output logic                    wr_ready,
    input  logic                    rd_en,
    input  logic [DEPTH_BITS-1:0]   rd_addr,
    output logic [LANES*2*CW-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    rd_release,
    output logic                    rd_ready,
    output logic                    fill_bank,
    output logic                    drain_bank,
    output logic [1:0]              banks_full,
    output logic [CNTW-1:0]         wr_count,
    output logic                    err_wr,
    output logic                    err_rd
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [1:0] full;
    logic [GWD-1:0] mem [0:1][0:WR_GROUPS-1][0:DEPTH-1];

    logic wr_fire;
    logic commit_fire;
    logic rd_fire;
    logic release_fire;

    assign wr_ready     = !full[fill_bank];
    assign rd_ready     = full[drain_bank];
    assign wr_fire      = wr_en && wr_ready;
    assign commit_fire  = wr_commit && wr_ready;
    assign rd_fire      = rd_en && rd_ready;
    assign release_fire = rd_release && rd_ready;
    assign banks_full   = {1'b0, full[0]} + {1'b0, full[1]};

    // RAM is deliberately unreset; a fill bank is never the drain bank while both are active.
    always_ff @(posedge clk) begin
        for (int g = 0; g < WR_GROUPS; g++) begin
            if (wr_fire && wr_group == GB'(g)) begin
                mem[fill_bank][g][wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                for (int g = 0; g < WR_GROUPS; g++) begin
                    rd_data[g*GWD +: GWD] <= mem[drain_bank][g][rd_addr];
                end
            end
        end
    end

    // Commit and release touch different banks whenever both are accepted, so they are independent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full       <= '0;
            fill_bank  <= 1'b0;
            drain_bank <= 1'b0;
            wr_count   <= '0;
            err_wr     <= 1'b0;
            err_rd     <= 1'b0;
        end else begin
            if (commit_fire) begin
                full[fill_bank] <= 1'b1;
                fill_bank       <= ~fill_bank;
            end
            if (release_fire) begin
                full[drain_bank] <= 1'b0;
                drain_bank       <= ~drain_bank;
            end
            if (commit_fire) begin
                wr_count <= '0;
            end else if (wr_fire && wr_count != CNT_MAX) begin
                wr_count <= wr_count + CNTW'(1);
            end
            if (!wr_ready && (wr_en || wr_commit)) begin
                err_wr <= 1'b1;
            end
            if (!rd_ready && (rd_en || rd_release)) begin
                err_rd <= 1'b1;
            end
        end
    end

endmodule
